// File: rtl/alert_tone_scheduler_pkg.sv
// Shared definitions for the alert tone scheduler.
//   state_t          : scheduler states (IDLE=0, PLAY=1, GAP=2)
//   BEAT_IDX_W       : width of the beat index handed to the tone lookup block
//   DEFAULT_BEAT_DIV : clocks per beat at 100 MHz for 8 beats/s
package alert_tone_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int BEAT_IDX_W       = 12;
  localparam int DEFAULT_BEAT_DIV = 12_500_000;

endpackage

// File: rtl/beat_tick_gen.sv
// Beat tick generator: a free-running divider that asserts tick for one cycle
// every BEAT_DIV clocks.
//   clk  : system clock
//   rst  : synchronous active-high reset, clears the count
//   clr  : synchronous clear, restarts the beat period from zero
//   tick : high in the cycle where the count equals BEAT_DIV-1
module beat_tick_gen
  import alert_tone_scheduler_pkg::*;
#(
  parameter int BEAT_DIV = DEFAULT_BEAT_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int              CNT_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEAT_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alert_tone_scheduler.sv
// Alert tone scheduler: grants the single speaker to one of NUM_REQ alert
// sources (index 0 highest priority), steps the beat index through one
// pattern, then holds a silent gap before the next grant.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   req       : level requests, held high while an alert is wanted
//   grant     : one-hot speaker owner, zero when idle or in the gap
//   tone_en   : tone block enable, high only while playing
//   ibeat_num : beat index for the tone block
//   busy      : high while playing or in the gap
//   done      : one-cycle pulse on the owner's bit when its pattern completes
module alert_tone_scheduler
  import alert_tone_scheduler_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int BEAT_DIV    = DEFAULT_BEAT_DIV,
  parameter int PATTERN_LEN = 32,
  parameter int GAP_BEATS   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  tone_en,
  output logic [BEAT_IDX_W-1:0] ibeat_num,
  output logic                  busy,
  output logic [NUM_REQ-1:0]    done
);

  localparam int                   GAP_W     = (GAP_BEATS > 1) ? $clog2(GAP_BEATS) : 1;
  localparam logic [GAP_W-1:0]      GAP_LAST  = GAP_W'(GAP_BEATS - 1);
  localparam logic [BEAT_IDX_W-1:0] BEAT_LAST = BEAT_IDX_W'(PATTERN_LEN - 1);

  state_t                state, state_n;
  logic [NUM_REQ-1:0]    grant_n, done_n;
  logic                  tone_en_n, busy_n;
  logic [BEAT_IDX_W-1:0] ibeat_n;
  logic [GAP_W-1:0]      gap_cnt, gap_cnt_n;
  logic                  tick, clr, owner_req;

  // One-hot of the lowest-index set bit; zero when nothing is requested.
  function automatic logic [NUM_REQ-1:0] pick_lowest(input logic [NUM_REQ-1:0] r);
    logic [NUM_REQ-1:0] pick;
    pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (r[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
    end
    return pick;
  endfunction

  // The beat period restarts on every state change so each phase begins with
  // a full beat, and the divider stays parked while idle.
  assign clr       = (state == IDLE) || (state_n != state);
  assign owner_req = |(req & grant);

  beat_tick_gen #(
    .BEAT_DIV (BEAT_DIV)
  ) u_beat_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  always_comb begin
    state_n   = state;
    grant_n   = grant;
    tone_en_n = tone_en;
    ibeat_n   = ibeat_num;
    busy_n    = busy;
    done_n    = '0;
    gap_cnt_n = gap_cnt;

    case (state)
      IDLE: begin
        if (|req) begin
          state_n   = PLAY;
          grant_n   = pick_lowest(req);
          tone_en_n = 1'b1;
          ibeat_n   = '0;
          busy_n    = 1'b1;
        end
      end

      PLAY: begin
        // Losing the owner's request wins over a coincident final tick, so an
        // aborted pattern never reports done.
        if (!owner_req) begin
          state_n   = GAP;
          grant_n   = '0;
          tone_en_n = 1'b0;
          ibeat_n   = '0;
          gap_cnt_n = '0;
        end else if (tick) begin
          if (ibeat_num == BEAT_LAST) begin
            state_n   = GAP;
            done_n    = grant;
            grant_n   = '0;
            tone_en_n = 1'b0;
            ibeat_n   = '0;
            gap_cnt_n = '0;
          end else begin
            ibeat_n = ibeat_num + BEAT_IDX_W'(1);
          end
        end
      end

      GAP: begin
        if (tick) begin
          if (gap_cnt == GAP_LAST) begin
            state_n   = IDLE;
            busy_n    = 1'b0;
            gap_cnt_n = '0;
          end else begin
            gap_cnt_n = gap_cnt + GAP_W'(1);
          end
        end
      end

      default: begin
        state_n   = IDLE;
        grant_n   = '0;
        tone_en_n = 1'b0;
        ibeat_n   = '0;
        busy_n    = 1'b0;
        gap_cnt_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      tone_en   <= 1'b0;
      ibeat_num <= '0;
      busy      <= 1'b0;
      done      <= '0;
      gap_cnt   <= '0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      tone_en   <= tone_en_n;
      ibeat_num <= ibeat_n;
      busy      <= busy_n;
      done      <= done_n;
      gap_cnt   <= gap_cnt_n;
    end
  end

endmodule

// File: tb/tb_alert_tone_scheduler.sv
// Bench for alert_tone_scheduler with BEAT_DIV=4, PATTERN_LEN=4, GAP_BEATS=2.
module tb_alert_tone_scheduler;

  localparam int NREQ = 2;
  localparam int BD   = 4;
  localparam int PL   = 4;
  localparam int GB   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [1:0]  grant;
  logic        tone_en;
  logic [11:0] ibeat_num;
  logic        busy;
  logic [1:0]  done;

  always #5 clk = ~clk;

  alert_tone_scheduler #(
    .NUM_REQ     (NREQ),
    .BEAT_DIV    (BD),
    .PATTERN_LEN (PL),
    .GAP_BEATS   (GB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .grant     (grant),
    .tone_en   (tone_en),
    .ibeat_num (ibeat_num),
    .busy      (busy),
    .done      (done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode 0 idle, 1 play, 2 gap; m_e counts cycles spent in
  // the current mode, beat index and phase ends derive from it arithmetically.
  int         m_mode  = 0;
  int         m_owner = 0;
  int         m_e     = 0;
  logic [1:0] x_grant = 2'b00;
  logic [1:0] x_done  = 2'b00;
  logic       x_tone  = 1'b0;
  logic       x_busy  = 1'b0;
  int         x_ibeat = 0;

  typedef struct {
    logic       r;
    logic [1:0] q;
    int         n;
    logic [1:0] g;
    logic       t;
    int         b;
    logic       bz;
    logic [1:0] d;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic [1:0] q);
    x_done = 2'b00;
    if (r) begin
      m_mode = 0; m_e = 0;
      x_grant = 2'b00; x_tone = 1'b0; x_ibeat = 0; x_busy = 1'b0;
    end else begin
      case (m_mode)
        0: begin
          if (q != 2'b00) begin
            for (int i = NREQ - 1; i >= 0; i--) if (q[i]) m_owner = i;
            m_mode = 1; m_e = 0;
            x_grant = 2'(1 << m_owner); x_tone = 1'b1; x_ibeat = 0; x_busy = 1'b1;
          end
        end
        1: begin
          if (!q[m_owner]) begin
            m_mode = 2; m_e = 0;
            x_grant = 2'b00; x_tone = 1'b0; x_ibeat = 0;
          end else if (m_e == PL * BD - 1) begin
            x_done = x_grant;
            m_mode = 2; m_e = 0;
            x_grant = 2'b00; x_tone = 1'b0; x_ibeat = 0;
          end else begin
            m_e++;
            x_ibeat = m_e / BD;
          end
        end
        default: begin
          if (m_e == GB * BD - 1) begin
            m_mode = 0; m_e = 0; x_busy = 1'b0;
          end else begin
            m_e++;
          end
        end
      endcase
    end
  endtask

  // Drive inputs, take one clock edge, then check every output against the model.
  task automatic cycle(input logic r, input logic [1:0] q);
    rst = r;
    req = q;
    @(posedge clk);
    model_step(r, q);
    @(negedge clk);
    chk("model_grant", int'(grant), int'(x_grant));
    chk("model_tone_en", int'(tone_en), int'(x_tone));
    chk("model_ibeat", int'(ibeat_num), x_ibeat);
    chk("model_busy", int'(busy), int'(x_busy));
    chk("model_done", int'(done), int'(x_done));
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || grant != 2'b00) && k < 40) begin
      cycle(1'b0, 2'b00);
      k++;
    end
    chk("idle_reached_busy", int'(busy), 0);
  endtask

  initial begin
    logic [1:0] rq;
    logic       rr;

    // Reset hold, then a single held request through play, gap and re-grant,
    // then an abort back to idle.
    vt.push_back(vec_t'{1'b1, 2'b11, 1, 2'b00, 1'b0, 0, 1'b0, 2'b00});
    vt.push_back(vec_t'{1'b1, 2'b11, 1, 2'b00, 1'b0, 0, 1'b0, 2'b00});
    vt.push_back(vec_t'{1'b1, 2'b11, 1, 2'b00, 1'b0, 0, 1'b0, 2'b00});
    vt.push_back(vec_t'{1'b0, 2'b10, 1, 2'b10, 1'b1, 0, 1'b1, 2'b00});
    vt.push_back(vec_t'{1'b0, 2'b10, 3, 2'b10, 1'b1, 0, 1'b1, 2'b00});
    vt.push_back(vec_t'{1'b0, 2'b10, 1, 2'b10, 1'b1, 1, 1'b1, 2'b00});
    vt.push_back(vec_t'{1'b0, 2'b10, 4, 2'b10, 1'b1, 2, 1'b1, 2'b00});
    vt.push_back(vec_t'{1'b0, 2'b10, 4, 2'b10, 1'b1, 3, 1'b1, 2'b00});
    vt.push_back(vec_t'{1'b0, 2'b10, 3, 2'b10, 1'b1, 3, 1'b1, 2'b00});
    vt.push_back(vec_t'{1'b0, 2'b10, 1, 2'b00, 1'b0, 0, 1'b1, 2'b10});
    vt.push_back(vec_t'{1'b0, 2'b10, 1, 2'b00, 1'b0, 0, 1'b1, 2'b00});
    vt.push_back(vec_t'{1'b0, 2'b10, 6, 2'b00, 1'b0, 0, 1'b1, 2'b00});
    vt.push_back(vec_t'{1'b0, 2'b10, 1, 2'b00, 1'b0, 0, 1'b0, 2'b00});
    vt.push_back(vec_t'{1'b0, 2'b10, 1, 2'b10, 1'b1, 0, 1'b1, 2'b00});
    vt.push_back(vec_t'{1'b0, 2'b00, 1, 2'b00, 1'b0, 0, 1'b1, 2'b00});
    vt.push_back(vec_t'{1'b0, 2'b00, 7, 2'b00, 1'b0, 0, 1'b1, 2'b00});
    vt.push_back(vec_t'{1'b0, 2'b00, 1, 2'b00, 1'b0, 0, 1'b0, 2'b00});

    for (int i = 0; i < vt.size(); i++) begin
      repeat (vt[i].n) cycle(vt[i].r, vt[i].q);
      chk($sformatf("vec%0d_grant", i), int'(grant), int'(vt[i].g));
      chk($sformatf("vec%0d_tone_en", i), int'(tone_en), int'(vt[i].t));
      chk($sformatf("vec%0d_ibeat", i), int'(ibeat_num), vt[i].b);
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vt[i].bz));
      chk($sformatf("vec%0d_done", i), int'(done), int'(vt[i].d));
    end

    // Simultaneous requests: index 0 first, then index 1 after the gap.
    cycle(1'b0, 2'b11);
    chk("simul_grant0", int'(grant), 1);
    repeat (16) cycle(1'b0, 2'b11);
    chk("simul_done0", int'(done), 1);
    repeat (8) cycle(1'b0, 2'b10);
    chk("simul_gap_end_busy", int'(busy), 0);
    cycle(1'b0, 2'b10);
    chk("simul_grant1", int'(grant), 2);
    wait_idle();

    // Late higher-priority request does not preempt.
    cycle(1'b0, 2'b10);
    repeat (4) cycle(1'b0, 2'b10);
    chk("late_ibeat1", int'(ibeat_num), 1);
    repeat (8) cycle(1'b0, 2'b11);
    chk("late_ibeat3", int'(ibeat_num), 3);
    chk("late_grant_kept", int'(grant), 2);
    repeat (4) cycle(1'b0, 2'b11);
    chk("late_done1", int'(done), 2);
    repeat (8) cycle(1'b0, 2'b11);
    chk("late_idle_busy", int'(busy), 0);
    cycle(1'b0, 2'b11);
    chk("late_grant0", int'(grant), 1);
    wait_idle();

    // Abort at beat 2.
    cycle(1'b0, 2'b01);
    repeat (8) cycle(1'b0, 2'b01);
    chk("abort_ibeat2", int'(ibeat_num), 2);
    cycle(1'b0, 2'b00);
    chk("abort_tone_en", int'(tone_en), 0);
    chk("abort_grant", int'(grant), 0);
    chk("abort_no_done", int'(done), 0);
    chk("abort_busy", int'(busy), 1);
    repeat (7) cycle(1'b0, 2'b00);
    chk("abort_gap_busy", int'(busy), 1);
    cycle(1'b0, 2'b00);
    chk("abort_idle_busy", int'(busy), 0);

    // Reset in the middle of a pattern.
    cycle(1'b0, 2'b01);
    repeat (8) cycle(1'b0, 2'b01);
    chk("rstmid_ibeat2", int'(ibeat_num), 2);
    cycle(1'b1, 2'b01);
    chk("rstmid_grant", int'(grant), 0);
    chk("rstmid_tone_en", int'(tone_en), 0);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_ibeat", int'(ibeat_num), 0);
    cycle(1'b0, 2'b01);
    chk("rstmid_regrant", int'(grant), 1);
    chk("rstmid_restart_ibeat", int'(ibeat_num), 0);
    repeat (4) cycle(1'b0, 2'b01);
    chk("rstmid_full_beat", int'(ibeat_num), 1);
    wait_idle();

    // Randomized request traffic with occasional resets.
    rq = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 23) == 0) rq = 2'($urandom_range(0, 3));
      rr = ($urandom_range(0, 299) == 0);
      cycle(rr, rq);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
